rcv_timing_ctrl: RTL and testbench

- Sequences bit timing for the serial receiver.
- On a detected start bit, times the mid-point of every data bit and the stop bit.
- Emits single-cycle strobes to the shift register and stop-bit checker, then signals packet completion.
- Sits between the start-bit detector and the receive shift register; owns the period and bit counters.

---
 rtl/rcv_timing_ctrl_pkg.sv | 22 ++
 rtl/rcv_timing_ctrl_if.sv | 33 +++
 rtl/rcv_timing_ctrl_tick_counter.sv | 46 ++++
 rtl/rcv_timing_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_rcv_timing_ctrl.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/rcv_timing_ctrl_pkg.sv
// rcv_timing_pkg
// Shared types and constants for the receive bit-timing controller.
// Contents:
//   state_e          FSM state encoding (PARITY is only reachable when
//                    RCV_TIMING_PARITY_BIT_EN is defined)
//   MIN_CLK_PER_BIT  smallest bit period the controller will run with
//   MIN_DATA_BITS    smallest data-bit count per packet
package rcv_timing_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HALF,
    DATA,
    PARITY,
    STOP,
    DONE
  } state_e;

  localparam int MIN_CLK_PER_BIT = 2;
  localparam int MIN_DATA_BITS   = 1;

endpackage

// File: rtl/rcv_timing_ctrl_if.sv
// rcv_timing_ctrl_if
// Groups the start-detector inputs, configuration, and timing outputs of
// rcv_timing_ctrl.
//   master : drives start_bit_detected, abort, clk_per_bit, data_bits;
//            observes strobes, busy, and bit_index
//   slave  : the controller side
interface rcv_timing_ctrl_if #(
  parameter int CLK_DIV_BITS = 4,
  parameter int BIT_CNT_BITS = 4
);

  logic                    start_bit_detected;
  logic                    abort;
  logic [CLK_DIV_BITS-1:0] clk_per_bit;
  logic [BIT_CNT_BITS-1:0] data_bits;
  logic                    shift_strobe;
  logic                    parity_strobe;
  logic                    stop_strobe;
  logic                    packet_done;
  logic                    busy;
  logic [BIT_CNT_BITS-1:0] bit_index;

  modport master (
    output start_bit_detected, abort, clk_per_bit, data_bits,
    input  shift_strobe, parity_strobe, stop_strobe, packet_done, busy, bit_index
  );

  modport slave (
    input  start_bit_detected, abort, clk_per_bit, data_bits,
    output shift_strobe, parity_strobe, stop_strobe, packet_done, busy, bit_index
  );

endinterface

// File: rtl/rcv_timing_ctrl_tick_counter.sv
// tick_counter
// Free-running 1..limit counter with a terminal-count tick.
// Ports:
//   clk, rst   clock and asynchronous active-high reset
//   clear_i    forces the count to 0 (takes priority over enable_i)
//   enable_i   advance the count this cycle
//   limit_i    terminal count
//   tick_o     high while count equals limit_i
//   count_o    current count
// After reaching limit_i while enabled, the count restarts at 1.
module tick_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear_i,
  input  logic             enable_i,
  input  logic [WIDTH-1:0] limit_i,
  output logic             tick_o,
  output logic [WIDTH-1:0] count_o
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  assign tick_o  = (count_q == limit_i);
  assign count_o = count_q;

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (enable_i) begin
      count_d = tick_o ? WIDTH'(1) : count_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/rcv_timing_ctrl.sv
// rcv_timing_ctrl
// Bit-timing sequencer for the serial receiver. After an accepted start
// bit it waits half a bit period, then strobes the middle of every data
// bit, the optional parity bit, and the stop bit, then pulses packet_done.
// Ports:
//   clk, rst   system clock, asynchronous active-high reset
//   bus        rcv_timing_ctrl_if.slave (start/abort/config in,
//              strobes/busy/bit_index out)
// Build option: define RCV_TIMING_PARITY_BIT_EN to insert a parity phase
// between DATA and STOP; otherwise parity_strobe is tied low.
//
// state  | meaning
// IDLE   | waiting for start_bit_detected
// HALF   | counting H = P/2 cycles to mid start bit
// DATA   | one shift_strobe per period, D in total
// PARITY | one parity_strobe one period after the last data bit
// STOP   | stop_strobe one period later, then DONE
// DONE   | packet_done cycle, back to IDLE
module rcv_timing_ctrl
  import rcv_timing_pkg::*;
#(
  parameter int CLK_DIV_BITS = 4,
  parameter int BIT_CNT_BITS = 4
) (
  input logic                clk,
  input logic                rst,
  rcv_timing_ctrl_if.slave   bus
);

  state_e state_q, state_d;

  logic [CLK_DIV_BITS-1:0] p_q, p_d;
  logic [BIT_CNT_BITS-1:0] d_q, d_d;
  logic shift_q, shift_d;
  logic stop_q, stop_d;
  logic done_q, done_d;
`ifdef RCV_TIMING_PARITY_BIT_EN
  logic parity_q, parity_d;
`endif

  logic                    accept;
  logic [CLK_DIV_BITS-1:0] p_clamp;
  logic [BIT_CNT_BITS-1:0] d_clamp;
  logic [CLK_DIV_BITS-1:0] per_limit;
  logic                    per_tick;
  logic [CLK_DIV_BITS-1:0] per_cnt_unused;
  logic                    bit_full;
  logic [BIT_CNT_BITS-1:0] bit_cnt;
  logic                    last_bit;

  assign p_clamp = (bus.clk_per_bit < CLK_DIV_BITS'(MIN_CLK_PER_BIT)) ?
                   CLK_DIV_BITS'(MIN_CLK_PER_BIT) : bus.clk_per_bit;
  assign d_clamp = (bus.data_bits < BIT_CNT_BITS'(MIN_DATA_BITS)) ?
                   BIT_CNT_BITS'(MIN_DATA_BITS) : bus.data_bits;

  // The counter is cleared to 0 on acceptance, so HALF ends on count H-1;
  // it then wraps to 1 and every later phase ends on count P.
  assign per_limit = (state_q == HALF) ? ((p_q >> 1) - CLK_DIV_BITS'(1)) : p_q;

  // bit_cnt already reflects all earlier strobes when the next one is due.
  assign last_bit = (bit_cnt == (d_q - BIT_CNT_BITS'(1)));

  tick_counter #(.WIDTH(CLK_DIV_BITS)) u_period_cnt (
    .clk      (clk),
    .rst      (rst),
    .clear_i  (accept),
    .enable_i (state_q != IDLE),
    .limit_i  (per_limit),
    .tick_o   (per_tick),
    .count_o  (per_cnt_unused)
  );

  tick_counter #(.WIDTH(BIT_CNT_BITS)) u_bit_cnt (
    .clk      (clk),
    .rst      (rst),
    .clear_i  (accept),
    .enable_i (shift_q),
    .limit_i  (d_q),
    .tick_o   (bit_full),
    .count_o  (bit_cnt)
  );

  always_comb begin
    state_d  = state_q;
    p_d      = p_q;
    d_d      = d_q;
    shift_d  = 1'b0;
    stop_d   = 1'b0;
    done_d   = 1'b0;
`ifdef RCV_TIMING_PARITY_BIT_EN
    parity_d = 1'b0;
`endif
    accept   = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.start_bit_detected && !bus.abort) begin
          accept  = 1'b1;
          p_d     = p_clamp;
          d_d     = d_clamp;
          state_d = HALF;
        end
      end
      HALF: begin
        if (per_tick) state_d = DATA;
      end
      DATA: begin
        if (per_tick && !bit_full) begin
          shift_d = 1'b1;
          if (last_bit) begin
`ifdef RCV_TIMING_PARITY_BIT_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end
      end
`ifdef RCV_TIMING_PARITY_BIT_EN
      PARITY: begin
        if (per_tick) begin
          parity_d = 1'b1;
          state_d  = STOP;
        end
      end
`endif
      STOP: begin
        // Stay in STOP through the stop-strobe cycle so DONE lines up with
        // the packet_done pulse.
        if (stop_q) begin
          done_d  = 1'b1;
          state_d = DONE;
        end else if (per_tick) begin
          stop_d = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // abort outranks any strobe due on the same edge.
    if (bus.abort && (state_q != IDLE)) begin
      state_d  = IDLE;
      shift_d  = 1'b0;
      stop_d   = 1'b0;
      done_d   = 1'b0;
`ifdef RCV_TIMING_PARITY_BIT_EN
      parity_d = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      p_q      <= '0;
      d_q      <= '0;
      shift_q  <= 1'b0;
      stop_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef RCV_TIMING_PARITY_BIT_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      p_q      <= p_d;
      d_q      <= d_d;
      shift_q  <= shift_d;
      stop_q   <= stop_d;
      done_q   <= done_d;
`ifdef RCV_TIMING_PARITY_BIT_EN
      parity_q <= parity_d;
`endif
    end
  end

  assign bus.shift_strobe  = shift_q;
  assign bus.stop_strobe   = stop_q;
  assign bus.packet_done   = done_q;
  assign bus.busy          = (state_q != IDLE);
  assign bus.bit_index     = bit_cnt;
`ifdef RCV_TIMING_PARITY_BIT_EN
  assign bus.parity_strobe = parity_q;
`else
  assign bus.parity_strobe = 1'b0;
`endif

endmodule

// File: tb/tb_rcv_timing_ctrl.sv
// tb_rcv_timing_ctrl
// Directed bench for rcv_timing_ctrl. Each accepted start pushes the
// expected pulse schedule into a queue; a negedge monitor compares the
// pulse outputs every cycle against the queue head. Build with
// RCV_TIMING_PARITY_BIT_EN defined to check the parity-phase schedule.
module tb_rcv_timing_ctrl;

  localparam int CW = 4;
  localparam int BW = 4;

  typedef struct {
    int         cyc;
    logic [3:0] kind;   // {shift, parity, stop, done}
  } ev_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   edge_cnt = 0;
  int   vectors = 0;
  int   miscompares = 0;
  ev_t  exp_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) edge_cnt++;

  rcv_timing_ctrl_if #(.CLK_DIV_BITS(CW), .BIT_CNT_BITS(BW)) bus ();

  rcv_timing_ctrl #(.CLK_DIV_BITS(CW), .BIT_CNT_BITS(BW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Every cycle: pulse outputs must equal the scheduled event for this
  // cycle, or all zero when nothing is scheduled.
  always @(negedge clk) begin
    logic [3:0] pulses;
    logic [3:0] expk;
    pulses = {bus.shift_strobe, bus.parity_strobe, bus.stop_strobe, bus.packet_done};
    expk   = 4'b0000;
    if (exp_q.size() > 0 && exp_q[0].cyc == edge_cnt) begin
      expk = exp_q[0].kind;
      void'(exp_q.pop_front());
    end
    vectors++;
    assert (pulses === expk) else begin
      miscompares++;
      $error("FAIL pulses@cycle%0d: observed %b expected %b", edge_cnt, pulses, expk);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic to_cycle(input int n);
    while (edge_cnt < n) @(negedge clk);
  endtask

  // Schedule for a start accepted at edge s with raw config p/d.
  function automatic void push_expect(input int s, input int p, input int d, output int done_c);
    int pe, de, h, tail;
    pe   = (p < 2) ? 2 : p;
    de   = (d < 1) ? 1 : d;
    h    = pe / 2;
    tail = de + 1;
    for (int k = 0; k < de; k++) exp_q.push_back('{cyc: s + h + (k + 1) * pe, kind: 4'b1000});
`ifdef RCV_TIMING_PARITY_BIT_EN
    exp_q.push_back('{cyc: s + h + (de + 1) * pe, kind: 4'b0100});
    tail = de + 2;
`endif
    exp_q.push_back('{cyc: s + h + tail * pe, kind: 4'b0010});
    exp_q.push_back('{cyc: s + h + tail * pe + 1, kind: 4'b0001});
    done_c = s + h + tail * pe + 1;
  endfunction

  // Call at a negedge; returns at the negedge of cycle s.
  task automatic start_pkt(input int p, input int d, output int s, output int done_c);
    bus.start_bit_detected = 1'b1;
    bus.clk_per_bit        = CW'(p);
    bus.data_bits          = BW'(d);
    s = edge_cnt + 1;
    push_expect(s, p, d, done_c);
    @(negedge clk);
    bus.start_bit_detected = 1'b0;
  endtask

  function automatic int shifts_before(input int s, input int p, input int d, input int cut);
    int pe, de, h, n;
    pe = (p < 2) ? 2 : p;
    de = (d < 1) ? 1 : d;
    h  = pe / 2;
    n  = 0;
    for (int k = 0; k < de; k++) if (s + h + (k + 1) * pe < cut) n++;
    return n;
  endfunction

  initial begin
    int s, dc, s2, dc2, cut, nsh;
    bus.start_bit_detected = 1'b0;
    bus.abort              = 1'b0;
    bus.clk_per_bit        = 4'd4;
    bus.data_bits          = 4'd8;

    // Reset state
    #1 rst = 1'b1;
    @(negedge clk);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_bit_index", 32'(bus.bit_index), 0);
    chk("rst_pulses", 32'({bus.shift_strobe, bus.parity_strobe, bus.stop_strobe, bus.packet_done}), 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Nominal P=4, D=8
    chk("nom_idle_busy", 32'(bus.busy), 0);
    start_pkt(4, 8, s, dc);
    chk("nom_busy_c0", 32'(bus.busy), 1);
    chk("nom_bit_index_c0", 32'(bus.bit_index), 0);
    to_cycle(s + 34);
    chk("nom_bit_index_c34", 32'(bus.bit_index), 7);
    to_cycle(s + 35);
    chk("nom_bit_index_c35", 32'(bus.bit_index), 8);
    to_cycle(dc);
    chk("nom_busy_done", 32'(bus.busy), 1);
    to_cycle(dc + 1);
    chk("nom_busy_after", 32'(bus.busy), 0);
    chk("nom_bit_index_idle", 32'(bus.bit_index), 8);
    to_cycle(dc + 2);
    chk("nom_queue_drained", 32'(exp_q.size()), 0);

    // Odd period P=5, D=1
    start_pkt(5, 1, s, dc);
    to_cycle(dc);
    chk("odd_busy_done", 32'(bus.busy), 1);
    to_cycle(dc + 1);
    chk("odd_busy_after", 32'(bus.busy), 0);
    chk("odd_bit_index", 32'(bus.bit_index), 1);
    to_cycle(dc + 2);
    chk("odd_queue_drained", 32'(exp_q.size()), 0);

    // abort in IDLE beats a simultaneous start
    bus.start_bit_detected = 1'b1;
    bus.abort              = 1'b1;
    @(negedge clk);
    bus.start_bit_detected = 1'b0;
    bus.abort              = 1'b0;
    chk("idle_abort_busy", 32'(bus.busy), 0);
    @(negedge clk);

    // Abort mid-packet, sampled at edge s+20
    bus.clk_per_bit = 4'd4;
    bus.data_bits   = 4'd8;
    start_pkt(4, 8, s, dc);
    to_cycle(s + 19);
    bus.abort = 1'b1;
    cut = s + 20;
    while (exp_q.size() > 0 && exp_q[exp_q.size() - 1].cyc >= cut) void'(exp_q.pop_back());
    nsh = shifts_before(s, 4, 8, cut);
    to_cycle(s + 20);
    bus.abort = 1'b0;
    chk("abort_busy", 32'(bus.busy), 0);
    chk("abort_bit_index", 32'(bus.bit_index), 32'(nsh));
    to_cycle(s + 45);
    chk("abort_bit_index_hold", 32'(bus.bit_index), 32'(nsh));
    chk("abort_busy_hold", 32'(bus.busy), 0);
    chk("abort_queue_drained", 32'(exp_q.size()), 0);

    // Ignored start and config changes while busy; start in first IDLE cycle accepted
    start_pkt(4, 8, s, dc);
    to_cycle(s + 10);
    bus.start_bit_detected = 1'b1;
    to_cycle(s + 11);
    bus.start_bit_detected = 1'b0;
    to_cycle(s + 12);
    bus.clk_per_bit = 4'd7;
    chk("ign_busy", 32'(bus.busy), 1);
    to_cycle(dc);
    bus.start_bit_detected = 1'b1;
    to_cycle(dc + 1);
    chk("ign_busy_first_idle", 32'(bus.busy), 0);
    s2 = edge_cnt + 1;
    push_expect(s2, 7, 8, dc2);
    @(negedge clk);
    bus.start_bit_detected = 1'b0;
    chk("ign_restart_busy", 32'(bus.busy), 1);
    chk("ign_restart_bit_index", 32'(bus.bit_index), 0);
    to_cycle(dc2 + 1);
    chk("ign2_busy_after", 32'(bus.busy), 0);
    chk("ign2_bit_index", 32'(bus.bit_index), 8);
    to_cycle(dc2 + 2);
    chk("ign2_queue_drained", 32'(exp_q.size()), 0);

    // Clamping: clk_per_bit=1, data_bits=0
    start_pkt(1, 0, s, dc);
    to_cycle(dc + 1);
    chk("clamp_busy_after", 32'(bus.busy), 0);
    chk("clamp_bit_index", 32'(bus.bit_index), 1);
    to_cycle(dc + 2);
    chk("clamp_queue_drained", 32'(exp_q.size()), 0);

    // Async reset mid-packet
    start_pkt(4, 8, s, dc);
    to_cycle(s + 15);
    chk("prerst_bit_index", 32'(bus.bit_index), 32'(shifts_before(s, 4, 8, s + 15)));
    #2 rst = 1'b1;
    #1;
    chk("arst_busy", 32'(bus.busy), 0);
    chk("arst_bit_index", 32'(bus.bit_index), 0);
    chk("arst_pulses", 32'({bus.shift_strobe, bus.parity_strobe, bus.stop_strobe, bus.packet_done}), 0);
    exp_q.delete();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    chk("arst_busy_quiet", 32'(bus.busy), 0);

    // Nominal rerun after reset
    start_pkt(4, 8, s, dc);
    to_cycle(dc);
    chk("rerun_busy_done", 32'(bus.busy), 1);
    to_cycle(dc + 2);
    chk("rerun_busy_after", 32'(bus.busy), 0);
    chk("rerun_bit_index", 32'(bus.bit_index), 8);
    chk("rerun_queue_drained", 32'(exp_q.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
